// File: rtl/dual_fifo_merge.sv
// Two independent valid/ready FIFOs merged onto one output port.
// Round-robin arbitration applies when both FIFOs hold data.
module dual_fifo_merge #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           in0_data,
  input  logic                       in0_valid,
  output logic                       in0_ready,
  input  logic [WIDTH-1:0]           in1_data,
  input  logic                       in1_valid,
  output logic                       in1_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_src,
  output logic [$clog2(DEPTH):0]     count0,
  output logic [$clog2(DEPTH):0]     count1
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem0_q [DEPTH];
  logic [WIDTH-1:0] mem0_d [DEPTH];
  logic [WIDTH-1:0] mem1_q [DEPTH];
  logic [WIDTH-1:0] mem1_d [DEPTH];
  logic [PW-1:0]    wptr0_q, wptr0_d, rptr0_q, rptr0_d;
  logic [PW-1:0]    wptr1_q, wptr1_d, rptr1_q, rptr1_d;
  logic [CW-1:0]    cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic             last_grant_q, last_grant_d;

  logic             grant;
  logic             push0, push1, pop, pop0, pop1;

  // Arbitration and handshakes, all from registered state only
  always_comb begin
    if ((cnt0_q != '0) && (cnt1_q != '0)) grant = ~last_grant_q;
    else if (cnt0_q != '0)                grant = 1'b0;
    else if (cnt1_q != '0)                grant = 1'b1;
    else                                  grant = last_grant_q;
  end

  assign in0_ready = (cnt0_q != FULL);
  assign in1_ready = (cnt1_q != FULL);
  assign out_valid = (cnt0_q != '0) || (cnt1_q != '0);
  assign out_src   = grant;
  assign out_data  = !out_valid ? '0 : (grant ? mem1_q[rptr1_q] : mem0_q[rptr0_q]);
  assign count0    = cnt0_q;
  assign count1    = cnt1_q;

  assign push0 = in0_valid && in0_ready && !reset;
  assign push1 = in1_valid && in1_ready && !reset;
  assign pop   = out_valid && out_ready;
  assign pop0  = pop && !grant;
  assign pop1  = pop && grant;

  always_comb begin
    mem0_d = mem0_q;
    mem1_d = mem1_q;
    if (push0) mem0_d[wptr0_q] = in0_data;
    if (push1) mem1_d[wptr1_q] = in1_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_comb begin
    wptr0_d      = push0 ? wptr0_q + PW'(1) : wptr0_q;
    wptr1_d      = push1 ? wptr1_q + PW'(1) : wptr1_q;
    rptr0_d      = pop0  ? rptr0_q + PW'(1) : rptr0_q;
    rptr1_d      = pop1  ? rptr1_q + PW'(1) : rptr1_q;
    cnt0_d       = cnt0_q + CW'(push0) - CW'(pop0);
    cnt1_d       = cnt1_q + CW'(push1) - CW'(pop1);
    last_grant_d = pop ? grant : last_grant_q;
  end

  always_ff @(posedge clk) begin
    mem0_q <= mem0_d;
    mem1_q <= mem1_d;
  end

  // Storage is left alone on reset; clearing the pointers discards it
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr0_q      <= '0;
      rptr0_q      <= '0;
      wptr1_q      <= '0;
      rptr1_q      <= '0;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
      last_grant_q <= 1'b1;
    end else begin
      wptr0_q      <= wptr0_d;
      rptr0_q      <= rptr0_d;
      wptr1_q      <= wptr1_d;
      rptr1_q      <= rptr1_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: tb/tb_dual_fifo_merge.sv
// Scoreboard bench for dual_fifo_merge: expected words queued at stimulus,
// popped and compared by a monitor whenever an output transfer occurs.
module tb_dual_fifo_merge;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] in0_data, in1_data, out_data;
  logic             in0_valid, in1_valid, in0_ready, in1_ready;
  logic             out_valid, out_ready, out_src;
  logic [CW-1:0]    count0, count1;

  int checks = 0;
  int errors = 0;
  logic [WIDTH:0] exp_q [$];
  logic [WIDTH:0] mon_e;

  dual_fifo_merge #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in0_data(in0_data), .in0_valid(in0_valid), .in0_ready(in0_ready),
    .in1_data(in1_data), .in1_valid(in1_valid), .in1_ready(in1_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_src(out_src), .count0(count0), .count1(count1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0 && !out_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk("drain_complete", {31'd0, ok}, 32'd1);
  endtask

  // Monitor: an output transfer happens at the next rising edge
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual=%0h required=none", out_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_data", {16'd0, out_data}, {16'd0, mon_e[WIDTH-1:0]});
        chk("out_src", {31'd0, out_src}, {31'd0, mon_e[WIDTH]});
      end
    end
  end

  initial begin
    reset = 1'b1;
    in0_data = '0; in1_data = '0;
    in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data",  {16'd0, out_data}, 32'd0);
    chk("rst_out_src",   {31'd0, out_src}, 32'd1);
    chk("rst_in0_ready", {31'd0, in0_ready}, 32'd1);
    chk("rst_in1_ready", {31'd0, in1_ready}, 32'd1);
    chk("rst_count0",    {29'd0, count0}, 32'd0);
    chk("rst_count1",    {29'd0, count1}, 32'd0);

    // Single word through ch0
    out_ready = 1'b1;
    in0_valid = 1'b1; in0_data = 16'hA5A5;
    exp_q.push_back({1'b0, 16'hA5A5});
    tick();
    in0_valid = 1'b0;
    chk("single_out_valid", {31'd0, out_valid}, 32'd1);
    chk("single_count0", {29'd0, count0}, 32'd1);
    tick();
    chk("single_after_valid", {31'd0, out_valid}, 32'd0);
    chk("single_after_count0", {29'd0, count0}, 32'd0);

    // Fill ch1, hold off the fifth word, then drain with it following
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      in1_valid = 1'b1; in1_data = WIDTH'(i);
      exp_q.push_back({1'b1, WIDTH'(i)});
      tick();
    end
    in1_data = 16'd5;
    exp_q.push_back({1'b1, 16'd5});
    chk("full_count1", {29'd0, count1}, 32'd4);
    chk("full_in1_ready", {31'd0, in1_ready}, 32'd0);
    tick();
    chk("held_count1", {29'd0, count1}, 32'd4);
    out_ready = 1'b1;
    tick();
    chk("pop_while_full_count1", {29'd0, count1}, 32'd3);
    tick();
    chk("push_pop_count1", {29'd0, count1}, 32'd3);
    in1_valid = 1'b0;
    drain();

    // Both channels loaded: round robin starting at ch0 after reset
    do_reset();
    out_ready = 1'b0;
    in0_valid = 1'b1; in0_data = 16'd10;
    in1_valid = 1'b1; in1_data = 16'd20;
    tick();
    in0_data = 16'd11; in1_data = 16'd21;
    tick();
    in0_valid = 1'b0; in1_valid = 1'b0;
    chk("rr_count0", {29'd0, count0}, 32'd2);
    chk("rr_count1", {29'd0, count1}, 32'd2);
    exp_q.push_back({1'b0, 16'd10});
    exp_q.push_back({1'b1, 16'd20});
    exp_q.push_back({1'b0, 16'd11});
    exp_q.push_back({1'b1, 16'd21});
    out_ready = 1'b1;
    drain();

    // Streaming 10 words on ch0, pointers wrap twice
    for (int i = 0; i < 10; i++) begin
      in0_valid = 1'b1; in0_data = WIDTH'(16'h0100 + i);
      exp_q.push_back({1'b0, WIDTH'(16'h0100 + i)});
      tick();
      chk("stream_count0_le1", {31'd0, (count0 <= 1)}, 32'd1);
    end
    in0_valid = 1'b0;
    drain();

    // Reset discards stored words and a simultaneous push
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in0_valid = 1'b1; in0_data = WIDTH'(16'h0700 + i);
      tick();
    end
    chk("preload_count0", {29'd0, count0}, 32'd3);
    in0_data = 16'hBEEF;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    in0_valid = 1'b0;
    chk("rst2_count0", {29'd0, count0}, 32'd0);
    chk("rst2_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst2_in0_ready", {31'd0, in0_ready}, 32'd1);
    chk("rst2_out_src", {31'd0, out_src}, 32'd1);
    in0_valid = 1'b1; in0_data = 16'h1234;
    exp_q.push_back({1'b0, 16'h1234});
    out_ready = 1'b1;
    tick();
    in0_valid = 1'b0;
    drain();

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
